pe_start_token_consumer: RTL and testbench

Consumer-side endpoint of an HLS start-token channel. It pops start tokens from the shift-register start FIFO that feeds a PE and converts each token into one ap_start/ap_ready handshake on the PE. It tracks outstanding PE invocations (started but not done) and applies a credit limit. The block sits between the start FIFO's read port and the PE's ap_ctrl_chain inputs, one instance per PE.

---
 rtl/pe_start_token_consumer.sv | 74 +++++++
 tb/tb_pe_start_token_consumer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pe_start_token_consumer.sv
// Start-token consumer: pops start tokens from the PE's start FIFO and turns each
// into one ap_start/ap_ready handshake, with a credit limit on in-flight calls.
module pe_start_token_consumer #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 en,
    input  logic                 start_empty_n,
    output logic                 start_read,
    output logic                 pe_ap_start,
    input  logic                 pe_ap_ready,
    input  logic                 pe_ap_done,
    output logic [CNT_WIDTH-1:0] inflight,
    output logic [15:0]          started_cnt,
    output logic                 busy,
    output logic                 err_underflow
);

    typedef enum logic {S_WAIT = 1'b0, S_START = 1'b1} state_t;

    localparam logic [CNT_WIDTH:0] MAX_W = (CNT_WIDTH+1)'(MAX_INFLIGHT);

    state_t             state, state_nxt;
    logic               acc, dn;
    logic [CNT_WIDTH:0] after_dn, nxt;

    assign acc      = pe_ap_start & pe_ap_ready;
    // A done pulse with nothing outstanding is an error, not a credit.
    assign dn       = pe_ap_done & (inflight != '0);
    assign after_dn = {1'b0, inflight} - (CNT_WIDTH+1)'(dn);
    assign nxt      = after_dn + (CNT_WIDTH+1)'(acc);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= S_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  if (start_read) state_nxt = S_START;
            S_START: if (acc && !start_read) state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        start_read  = 1'b0;
        pe_ap_start = (state == S_START);
        busy        = (state == S_START) || (inflight != '0);
        case (state)
            S_WAIT:  start_read = en & start_empty_n & (after_dn < MAX_W);
            // A new token is only popped as the current one is accepted.
            S_START: start_read = acc & en & start_empty_n & (nxt < MAX_W);
            default: start_read = 1'b0;
        endcase
        if (ap_rst) start_read = 1'b0;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            inflight      <= '0;
            started_cnt   <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= nxt[CNT_WIDTH-1:0];
            if (acc) started_cnt <= started_cnt + 16'd1;
            if (pe_ap_done && inflight == '0) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_start_token_consumer.sv
// Directed bench for pe_start_token_consumer: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_pe_start_token_consumer;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        en;
    logic        start_empty_n;
    logic        start_read;
    logic        pe_ap_start;
    logic        pe_ap_ready;
    logic        pe_ap_done;
    logic [2:0]  inflight;
    logic [15:0] started_cnt;
    logic        busy;
    logic        err_underflow;

    int vectors    = 0;
    int miscompares = 0;
    int pops;

    pe_start_token_consumer #(.MAX_INFLIGHT(4), .CNT_WIDTH(3)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .en(en), .start_empty_n(start_empty_n),
        .start_read(start_read), .pe_ap_start(pe_ap_start), .pe_ap_ready(pe_ap_ready),
        .pe_ap_done(pe_ap_done), .inflight(inflight), .started_cnt(started_cnt),
        .busy(busy), .err_underflow(err_underflow)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic cyc;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic smp;
        @(negedge ap_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        ap_rst = 1'b1; en = 1'b1; start_empty_n = 1'b1; pe_ap_ready = 1'b0; pe_ap_done = 1'b0;
        smp;
        chk("rst_read", 32'(start_read), 32'd0);
        chk("rst_start", 32'(pe_ap_start), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_started", 32'(started_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        cyc; start_empty_n = 1'b0;
        cyc; ap_rst = 1'b0;

        // single token, PE ready on first request
        cyc; start_empty_n = 1'b1; pe_ap_ready = 1'b1;
        smp; chk("t1_read", 32'(start_read), 32'd1); chk("t1_start0", 32'(pe_ap_start), 32'd0);
        cyc; start_empty_n = 1'b0;
        smp; chk("t1_start", 32'(pe_ap_start), 32'd1); chk("t1_read_off", 32'(start_read), 32'd0);
        cyc;
        smp; chk("t1_inflight", 32'(inflight), 32'd1); chk("t1_started", 32'(started_cnt), 32'd1);
        chk("t1_start_off", 32'(pe_ap_start), 32'd0); chk("t1_busy", 32'(busy), 32'd1);
        cyc; cyc; pe_ap_done = 1'b1;
        cyc; pe_ap_done = 1'b0;
        smp; chk("t1_done_inflight", 32'(inflight), 32'd0); chk("t1_idle_busy", 32'(busy), 32'd0);

        // enable low blocks pops
        cyc; en = 1'b0; start_empty_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp; chk("en0_read", 32'(start_read), 32'd0); chk("en0_start", 32'(pe_ap_start), 32'd0);
            cyc;
        end

        // credit stall at MAX_INFLIGHT
        en = 1'b1; pops = 0;
        for (int i = 0; i < 8; i++) begin
            smp; pops += int'(start_read);
            cyc;
        end
        smp; chk("stall_pops", 32'(pops), 32'd4); chk("stall_read", 32'(start_read), 32'd0);
        chk("stall_inflight", 32'(inflight), 32'd4);
        cyc; pe_ap_done = 1'b1;
        smp; chk("credit_read", 32'(start_read), 32'd1);
        cyc; pe_ap_done = 1'b0; pops = 0;
        for (int i = 0; i < 5; i++) begin
            smp; pops += int'(start_read);
            cyc;
        end
        smp; chk("credit_extra_pops", 32'(pops), 32'd0); chk("credit_inflight", 32'(inflight), 32'd4);
        cyc; start_empty_n = 1'b0; pe_ap_done = 1'b1;
        cyc; cyc; cyc;
        cyc; pe_ap_done = 1'b0;
        smp; chk("drain_inflight", 32'(inflight), 32'd0); chk("drain_err", 32'(err_underflow), 32'd0);
        chk("drain_started", 32'(started_cnt), 32'd6);

        // PE backpressure for 7 cycles
        cyc; pe_ap_ready = 1'b0; start_empty_n = 1'b1;
        smp; chk("bp_read", 32'(start_read), 32'd1);
        for (int i = 0; i < 7; i++) begin
            cyc; smp;
            chk("bp_start_hold", 32'(pe_ap_start), 32'd1);
            chk("bp_no_read", 32'(start_read), 32'd0);
            chk("bp_inflight", 32'(inflight), 32'd0);
        end
        cyc; pe_ap_ready = 1'b1; start_empty_n = 1'b0;
        smp; chk("bp_acc_start", 32'(pe_ap_start), 32'd1);
        cyc;
        smp; chk("bp_inflight_inc", 32'(inflight), 32'd1); chk("bp_started", 32'(started_cnt), 32'd7);

        // accept and done in the same cycle at inflight 2
        cyc; start_empty_n = 1'b1;
        cyc; start_empty_n = 1'b0;
        cyc; start_empty_n = 1'b1;
        smp; chk("sim_pre_inflight", 32'(inflight), 32'd2); chk("sim_read", 32'(start_read), 32'd1);
        cyc; start_empty_n = 1'b0; pe_ap_done = 1'b1;
        smp; chk("sim_start", 32'(pe_ap_start), 32'd1);
        cyc; pe_ap_done = 1'b0;
        smp; chk("sim_inflight", 32'(inflight), 32'd2); chk("sim_started", 32'(started_cnt), 32'd9);
        cyc; pe_ap_done = 1'b1;
        cyc;
        cyc; pe_ap_done = 1'b0;
        smp; chk("sim_drain", 32'(inflight), 32'd0); chk("sim_err", 32'(err_underflow), 32'd0);

        // underflow is sticky and does not wrap inflight
        cyc; pe_ap_done = 1'b1;
        cyc; pe_ap_done = 1'b0;
        smp; chk("uf_err", 32'(err_underflow), 32'd1); chk("uf_inflight", 32'(inflight), 32'd0);
        cyc;
        smp; chk("uf_sticky", 32'(err_underflow), 32'd1);

        // async reset while a start is pending
        cyc; pe_ap_ready = 1'b0; start_empty_n = 1'b1;
        cyc; start_empty_n = 1'b0;
        smp; chk("rm_start_pre", 32'(pe_ap_start), 32'd1);
        #1 ap_rst = 1'b1; start_empty_n = 1'b1;
        #1;
        chk("rm_start", 32'(pe_ap_start), 32'd0); chk("rm_read", 32'(start_read), 32'd0);
        chk("rm_started", 32'(started_cnt), 32'd0); chk("rm_err", 32'(err_underflow), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0); chk("rm_inflight", 32'(inflight), 32'd0);
        cyc; start_empty_n = 1'b0;
        cyc; ap_rst = 1'b0;
        smp; chk("rm_token_dropped", 32'(pe_ap_start), 32'd0);

        // started_cnt wraps after 65536 accepts
        cyc; pe_ap_ready = 1'b1; pe_ap_done = 1'b1; start_empty_n = 1'b1;
        repeat (65535) cyc;
        start_empty_n = 1'b0;
        cyc;
        smp; chk("wrap_max", 32'(started_cnt), 32'd65535);
        cyc; pe_ap_done = 1'b0; start_empty_n = 1'b1;
        cyc; start_empty_n = 1'b0;
        cyc;
        smp; chk("wrap_zero", 32'(started_cnt), 32'd0); chk("wrap_inflight", 32'(inflight), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
